// File: rtl/spi_instr_prefetch.sv
// Instruction prefetch front-end: streams 16-bit words from a 23LC-style SPI SRAM
// (READ 0x03, sequential mode) into a small FIFO presented against the core PC.
module spi_instr_prefetch #(
    parameter int DEPTH   = 4,
    parameter int CS_IDLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] pc_addr,
    input  logic        advance,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [3:0]  fifo_level,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = ($clog2(CS_IDLE) > 5) ? $clog2(CS_IDLE) : 5;
    localparam logic [7:0] READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        DESEL,
        CMD,
        ADDR,
        DATA,
        STALL
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [15:0]     head_addr;
    logic [15:0]     byte_addr;
    logic [14:0]     shift_in;
    logic [15:0]     fifo_mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [3:0]      level, level_nxt;
    logic            pop, push, redirect, wr_en;
    logic            cs_nxt, sck_nxt, mosi_nxt;

    assign byte_addr   = {head_addr[14:0], 1'b0};
    assign instr_valid = (level != 4'd0) && (pc_addr == head_addr);
    assign instr       = (level != 4'd0) ? fifo_mem[rd_ptr] : 16'h0000;
    assign fifo_level  = level;
    assign pop         = advance && instr_valid;
    // The burst is always open outside reset, so any PC off the head is a branch target.
    assign redirect    = (pc_addr != head_addr) && !pop;
    assign push        = (state == DATA) && (cnt == CW'(31));
    assign wr_en       = push && !redirect && rst_n && ena;
    assign level_nxt   = level + {3'b000, push} - {3'b000, pop};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        unique case (state)
            DESEL: begin
                if (cnt == CW'(CS_IDLE - 1)) begin
                    state_nxt = CMD;
                    cnt_nxt   = '0;
                end
            end
            CMD: begin
                if (cnt == CW'(15)) begin
                    state_nxt = ADDR;
                    cnt_nxt   = '0;
                end
            end
            ADDR: begin
                if (cnt == CW'(31)) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (cnt == CW'(31)) begin
                    cnt_nxt = '0;
                    if (level_nxt == 4'(DEPTH)) begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                cnt_nxt = '0;
                if (level < 4'(DEPTH)) begin
                    state_nxt = DATA;
                end
            end
            default: begin
                state_nxt = DESEL;
                cnt_nxt   = '0;
            end
        endcase
        if (redirect) begin
            state_nxt = DESEL;
            cnt_nxt   = '0;
        end

        // SPI pins are registered from the next-state view so they never glitch.
        cs_nxt   = (state_nxt == DESEL);
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b0;
        case (state_nxt)
            CMD: begin
                sck_nxt  = cnt_nxt[0];
                mosi_nxt = READ_CMD[~cnt_nxt[3:1]];
            end
            ADDR: begin
                sck_nxt  = cnt_nxt[0];
                mosi_nxt = byte_addr[~cnt_nxt[4:1]];
            end
            DATA: begin
                sck_nxt = cnt_nxt[0];
            end
            default: begin
                sck_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state     <= DESEL;
            cnt       <= '0;
            head_addr <= pc_addr;
            level     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            shift_in  <= '0;
            spi_cs    <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            spi_cs   <= cs_nxt;
            spi_sck  <= sck_nxt;
            spi_mosi <= mosi_nxt;
            if (redirect) begin
                head_addr <= pc_addr;
                level     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
            end else begin
                if (pop) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    head_addr <= head_addr + 16'd1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                level <= level_nxt;
            end
            // MISO arrives one clk late, so it is taken at the edge closing the high phase.
            if (state == DATA && cnt[0]) begin
                shift_in <= {shift_in[13:0], spi_miso};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {shift_in, spi_miso};
        end
    end

endmodule

// File: tb/tb_spi_instr_prefetch.sv
// Self-checking bench for spi_instr_prefetch: behavioural 23LC SRAM with a one-flop
// MISO synchroniser, and expected instructions computed directly from the SRAM image.
module tb_spi_instr_prefetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] pc_addr;
    logic        advance;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  fifo_level;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  sram [0:65535];
    logic        prev_sck    = 1'b0;
    logic        miso_raw    = 1'b0;
    int          sram_bits   = 0;
    int          sram_bitpos = 0;
    logic [23:0] sram_shift  = '0;
    logic [15:0] sram_ptr    = '0;
    logic [7:0]  sram_cmd    = '0;
    logic [15:0] sram_addr   = '0;
    logic [7:0]  sram_byte;

    spi_instr_prefetch #(.DEPTH(4), .CS_IDLE(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .pc_addr     (pc_addr),
        .advance     (advance),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fifo_level  (fifo_level),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    // SRAM samples MOSI on SCK rise, drives data after SCK fall; MISO reaches the DUT one clk later.
    always @(negedge clk) begin
        spi_miso = miso_raw;
        if (spi_cs !== 1'b0) begin
            sram_bits   = 0;
            sram_bitpos = 0;
            prev_sck    = 1'b0;
            miso_raw    = 1'b0;
        end else begin
            if (spi_sck && !prev_sck && sram_bits < 24) begin
                sram_shift = {sram_shift[22:0], spi_mosi};
                sram_bits++;
                if (sram_bits == 24) begin
                    sram_cmd  = sram_shift[23:16];
                    sram_addr = sram_shift[15:0];
                    sram_ptr  = sram_shift[15:0];
                end
            end else if (!spi_sck && prev_sck && sram_bits >= 24) begin
                sram_byte = sram[sram_ptr];
                miso_raw  = sram_byte[3'(7 - sram_bitpos)];
                sram_bitpos++;
                if (sram_bitpos == 8) begin
                    sram_bitpos = 0;
                    sram_ptr    = sram_ptr + 16'd1;
                end
            end
            prev_sck = spi_sck;
        end
    end

    function automatic logic [15:0] ref_word(input logic [15:0] pc);
        logic [15:0] b;
        b = {pc[14:0], 1'b0};
        return {sram[b], sram[b + 16'd1]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset(input logic [15:0] pc);
        cyc();
        rst_n   = 1'b0;
        ena     = 1'b1;
        advance = 1'b0;
        pc_addr = pc;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic measure_first_valid(input int limit, output int lat,
                                       output logic [2:0] cs_hist, output logic [3:0] lvl0);
        lat     = -1;
        cs_hist = '0;
        lvl0    = '1;
        for (int c = 0; c <= limit; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            if (c == 0) lvl0 = fifo_level;
            if (c < 3) cs_hist = {spi_cs, cs_hist[2:1]};
            if (instr_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_level(input logic [3:0] target, input int limit, output bit reached);
        reached = 1'b0;
        for (int i = 0; i <= limit; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            if (fifo_level >= target) begin
                reached = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ena     = 1'b1;
        advance = 1'b0;
        pc_addr = 16'h0000;
        cyc();
        cyc();
        @(negedge clk);
        tests_run++;
        if (spi_cs !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cs: got %b expected 1", spi_cs); end
        tests_run++;
        if (spi_sck !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sck: got %b expected 0", spi_sck); end
        tests_run++;
        if (spi_mosi !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mosi: got %b expected 0", spi_mosi); end
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        tests_run++;
        if (fifo_level !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        tests_run++;
        if (instr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected 0000", instr); end
    endtask

    task automatic test_first_fetch();
        int         lat;
        logic [2:0] cs_hist;
        logic [3:0] lvl0;
        sram[0] = 8'h12;
        sram[1] = 8'h34;
        release_reset(16'h0000);
        measure_first_valid(200, lat, cs_hist, lvl0);
        tests_run++;
        if (cs_hist !== 3'b011) begin tests_failed++; $display("[TB] FAIL first_cs_idle: got cs{2,1,0}=%b expected 011", cs_hist); end
        tests_run++;
        if (lat != 82) begin tests_failed++; $display("[TB] FAIL first_latency: got %0d expected 82", lat); end
        tests_run++;
        if (instr !== 16'h1234) begin tests_failed++; $display("[TB] FAIL first_instr: got %h expected 1234", instr); end
        tests_run++;
        if (sram_cmd !== 8'h03) begin tests_failed++; $display("[TB] FAIL first_cmd: got %h expected 03", sram_cmd); end
        tests_run++;
        if (sram_addr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL first_addr: got %h expected 0000", sram_addr); end
    endtask

    task automatic test_stall();
        logic [15:0] pc;
        logic [15:0] exp_pc;
        bit          reached;
        bit          bad;
        bit          popped;
        int          lat;
        logic [3:0]  lvl_after;
        pc = 16'($urandom);
        release_reset(pc);
        wait_level(4'd4, 400, reached);
        tests_run++;
        if (!reached) begin tests_failed++; $display("[TB] FAIL stall_fill: got level %0d expected 4", fifo_level); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            @(negedge clk);
            if (spi_cs !== 1'b0 || spi_sck !== 1'b0 || fifo_level !== 4'd4) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("[TB] FAIL stall_hold: got cs=%b sck=%b level=%0d expected cs=0 sck=0 level=4", spi_cs, spi_sck, fifo_level); end
        tests_run++;
        if (instr_valid !== 1'b1 || instr !== ref_word(pc)) begin
            tests_failed++;
            $display("[TB] FAIL stall_head: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, ref_word(pc));
        end
        cyc();
        advance = 1'b1;
        @(negedge clk);
        popped = instr_valid;
        cyc();
        advance = 1'b0;
        pc_addr = pc + 16'd1;
        lat = -1;
        lvl_after = '1;
        for (int n = 1; n <= 80; n++) begin
            if (n > 1) cyc();
            @(negedge clk);
            if (n == 1) lvl_after = fifo_level;
            if (fifo_level == 4'd4) begin
                lat = n;
                break;
            end
        end
        tests_run++;
        if (!popped || lvl_after !== 4'd3) begin tests_failed++; $display("[TB] FAIL stall_pop: got popped=%b level=%0d expected popped=1 level=3", popped, lvl_after); end
        tests_run++;
        if (lat != 34) begin tests_failed++; $display("[TB] FAIL stall_refill: got %0d cycles expected 34", lat); end
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            @(negedge clk);
            if (fifo_level !== 4'd4) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("[TB] FAIL stall_one_word: got level %0d expected 4", fifo_level); end
        exp_pc = pc + 16'd1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            advance = 1'b1;
            pc_addr = exp_pc;
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b1 || instr !== ref_word(exp_pc)) begin
                tests_failed++;
                $display("[TB] FAIL stall_drain: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, ref_word(exp_pc));
            end else begin
                exp_pc = exp_pc + 16'd1;
            end
        end
        cyc();
        advance = 1'b0;
        pc_addr = exp_pc;
    endtask

    task automatic test_sequential();
        logic [15:0] start_pc;
        int          popped;
        int          cyc_cnt;
        bit          cs_rose;
        bit          just_popped;
        start_pc = 16'($urandom);
        popped   = 0;
        cyc_cnt  = 0;
        cs_rose  = 1'b0;
        release_reset(start_pc);
        while (popped < 8 && cyc_cnt < 3000) begin
            advance = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (cyc_cnt >= 2 && spi_cs !== 1'b0) cs_rose = 1'b1;
            just_popped = 1'b0;
            if (instr_valid === 1'b1 && advance) begin
                tests_run++;
                if (instr !== ref_word(start_pc + 16'(popped))) begin
                    tests_failed++;
                    $display("[TB] FAIL seq_instr: got %h expected %h", instr, ref_word(start_pc + 16'(popped)));
                end
                popped++;
                just_popped = 1'b1;
            end
            cyc();
            cyc_cnt++;
            if (just_popped) pc_addr = pc_addr + 16'd1;
        end
        advance = 1'b0;
        tests_run++;
        if (popped != 8) begin tests_failed++; $display("[TB] FAIL seq_count: got %0d expected 8", popped); end
        tests_run++;
        if (cs_rose) begin tests_failed++; $display("[TB] FAIL seq_cs: got cs high mid-burst expected cs low"); end
    endtask

    task automatic test_redirect();
        logic [15:0] pc;
        bit          reached;
        int          lat;
        logic [2:0]  cs_hist;
        logic [3:0]  lvl0;
        do pc = 16'($urandom); while (pc == 16'h0100);
        release_reset(pc);
        wait_level(4'd3, 400, reached);
        tests_run++;
        if (!reached || fifo_level !== 4'd3) begin tests_failed++; $display("[TB] FAIL redir_prefill: got level %0d expected 3", fifo_level); end
        cyc();
        pc_addr = 16'h0100;
        @(negedge clk);
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_valid_now: got %b expected 0", instr_valid); end
        cyc();
        measure_first_valid(200, lat, cs_hist, lvl0);
        tests_run++;
        if (lvl0 !== 4'd0) begin tests_failed++; $display("[TB] FAIL redir_flush: got level %0d expected 0", lvl0); end
        tests_run++;
        if (cs_hist !== 3'b011) begin tests_failed++; $display("[TB] FAIL redir_cs_idle: got cs{2,1,0}=%b expected 011", cs_hist); end
        tests_run++;
        if (lat != 82) begin tests_failed++; $display("[TB] FAIL redir_latency: got %0d expected 82", lat); end
        tests_run++;
        if (instr !== ref_word(16'h0100)) begin tests_failed++; $display("[TB] FAIL redir_instr: got %h expected %h", instr, ref_word(16'h0100)); end
        tests_run++;
        if (sram_addr !== 16'h0200) begin tests_failed++; $display("[TB] FAIL redir_addr: got %h expected 0200", sram_addr); end
    endtask

    task automatic test_wrap();
        bit reached;
        bit popped;
        release_reset(16'hFFFF);
        wait_level(4'd2, 300, reached);
        tests_run++;
        if (!reached || instr_valid !== 1'b1 || instr !== ref_word(16'hFFFF)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_first: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, ref_word(16'hFFFF));
        end
        tests_run++;
        if (sram_addr !== 16'hFFFE) begin tests_failed++; $display("[TB] FAIL wrap_addr: got %h expected fffe", sram_addr); end
        cyc();
        advance = 1'b1;
        @(negedge clk);
        popped = instr_valid;
        cyc();
        advance = 1'b0;
        pc_addr = 16'h0000;
        @(negedge clk);
        tests_run++;
        if (!popped || instr_valid !== 1'b1 || instr !== ref_word(16'h0000)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_next: got popped=%b valid=%b instr=%h expected 1 1 %h", popped, instr_valid, instr, ref_word(16'h0000));
        end
    endtask

    task automatic test_abort(input bit use_ena);
        logic [15:0] pc;
        int          lat;
        logic [2:0]  cs_hist;
        logic [3:0]  lvl0;
        string       tag;
        tag = use_ena ? "abort_ena" : "abort_rst";
        pc  = 16'($urandom);
        release_reset(pc);
        for (int c = 1; c <= 30; c++) cyc();
        if (use_ena) ena = 1'b0;
        else rst_n = 1'b0;
        cyc();
        @(negedge clk);
        tests_run++;
        if ({spi_cs, spi_sck, spi_mosi, instr_valid, fifo_level} !== 8'b1000_0000) begin
            tests_failed++;
            $display("[TB] FAIL %s_state: got cs=%b sck=%b mosi=%b valid=%b level=%0d expected 1 0 0 0 0",
                     tag, spi_cs, spi_sck, spi_mosi, instr_valid, fifo_level);
        end
        cyc();
        ena   = 1'b1;
        rst_n = 1'b1;
        measure_first_valid(200, lat, cs_hist, lvl0);
        tests_run++;
        if (lat != 82) begin tests_failed++; $display("[TB] FAIL %s_latency: got %0d expected 82", tag, lat); end
        tests_run++;
        if (instr !== ref_word(pc)) begin tests_failed++; $display("[TB] FAIL %s_instr: got %h expected %h", tag, instr, ref_word(pc)); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 8'($urandom);
        test_reset();
        test_first_fetch();
        test_stall();
        test_sequential();
        test_redirect();
        test_wrap();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
